// File: rtl/taylor_exp_reconstruct.sv
// Exponent reconstruction for the exponential unit: scales the Q2.30
// polynomial result p ~ e^r by 2^k with a one-bit-per-cycle shifter,
// rounds half-up on the last bit shifted out, and presents a Q16.16
// result with saturation / underflow flags on a valid/ready handshake.
module taylor_exp_reconstruct #(
    parameter int DW       = 32,
    parameter int FRAC_IN  = 30,
    parameter int FRAC_OUT = 16,
    parameter int KW       = 6
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] p_in,
    input  logic [KW-1:0] k_in,
    output logic [DW-1:0] y_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sat,
    output logic          uflow,
    output logic          busy
);

    // Signed shift amount needs two extra bits so k - (FRAC_IN-FRAC_OUT)
    // cannot wrap for any k.
    localparam int SW = KW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   reg_q, reg_d;      // working shift register
    logic            guard_q, guard_d;  // last bit shifted out on the right
    logic [SW-1:0]   cnt_q, cnt_d;      // remaining shift steps
    logic            right_q, right_d;  // 1: shift right, 0: shift left
    logic            pnz_q, pnz_d;      // the accepted p_in was nonzero
    logic [DW-1:0]   y_q, y_d;
    logic            sat_q, sat_d;
    logic            uflow_q, uflow_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic [SW-1:0]   s;
    logic [SW-1:0]   s_mag;
    logic            s_neg;
    logic            s_zero;
    logic            s_too_small;
    logic [DW:0]     round_sum;

    // Shift amount and its magnitude; anything below -DW shifts every
    // bit (guard included) out, so the result is known to be zero.
    always_comb begin
        s           = {{2{k_in[KW-1]}}, k_in} - SW'(FRAC_IN - FRAC_OUT);
        s_neg       = s[SW-1];
        s_mag       = s_neg ? (~s + 1'b1) : s;
        s_zero      = (s == '0);
        s_too_small = s_neg && (s_mag > SW'(DW));
        round_sum   = {1'b0, reg_q} + {{DW{1'b0}}, guard_q};
    end

    // Next-state and datapath: accept, iterate the shifter, round, hold.
    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        guard_d  = guard_q;
        cnt_d    = cnt_q;
        right_d  = right_q;
        pnz_d    = pnz_q;
        y_d      = y_q;
        sat_d    = sat_q;
        uflow_d  = uflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    reg_d   = p_in;
                    guard_d = 1'b0;
                    cnt_d   = s_mag;
                    right_d = s_neg;
                    pnz_d   = |p_in;
                    sat_d   = 1'b0;
                    uflow_d = 1'b0;
                    if (s_zero) begin
                        state_d = ROUND;
                    end else if (s_too_small) begin
                        reg_d   = '0;
                        uflow_d = |p_in;
                        state_d = ROUND;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (right_q) begin
                    // Only the most recent bit out is kept; no sticky bit.
                    guard_d = reg_q[0];
                    reg_d   = reg_q >> 1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == SW'(1)) state_d = ROUND;
                end else if (reg_q[DW-1]) begin
                    // A set MSB would be lost by the next left shift.
                    y_d     = '1;
                    sat_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    reg_d   = reg_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == SW'(1)) state_d = ROUND;
                end
            end

            ROUND: begin
                if (round_sum[DW]) begin
                    y_d   = '1;
                    sat_d = 1'b1;
                end else begin
                    y_d   = round_sum[DW-1:0];
                end
                uflow_d = pnz_q && (y_d == '0);
                state_d = HOLD;
            end

            HOLD: begin
                if (out_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Handshake/status outputs are registered and follow the next state.
        out_valid_d = (state_d == HOLD);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            guard_q     <= 1'b0;
            cnt_q       <= '0;
            right_q     <= 1'b0;
            pnz_q       <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
            uflow_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            guard_q     <= guard_d;
            cnt_q       <= cnt_d;
            right_q     <= right_d;
            pnz_q       <= pnz_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
            uflow_q     <= uflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign y_out     = y_q;
    assign sat       = sat_q;
    assign uflow     = uflow_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_taylor_exp_reconstruct.sv
// Scoreboard bench for taylor_exp_reconstruct: accepted jobs push the
// reference result (computed arithmetically from p and k) into a queue,
// and a monitor pops and compares each result the DUT presents.
module tb_taylor_exp_reconstruct;

    logic        CLK;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] p_in;
    logic [5:0]  k_in;
    logic [31:0] y_out;
    logic        out_valid;
    logic        out_ready;
    logic        sat;
    logic        uflow;
    logic        busy;

    taylor_exp_reconstruct dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .k_in      (k_in),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .uflow     (uflow),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] y;
        logic        sat;
        logic        uflow;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // y = p * 2^(k-14): right scaling rounds half-up on the highest
    // discarded bit only; left scaling saturates when the value leaves
    // 32 bits. Latency counts the accept edge as cycle 1.
    function automatic exp_t model(input logic [31:0] p, input logic [5:0] k);
        exp_t   e;
        int     s;
        int     msb;
        longint v;
        s   = int'($signed(k)) - 14;
        msb = -1;
        for (int i = 0; i < 32; i++) if (p[i]) msb = i;
        e.sat = 1'b0;
        e.acc = 0;
        if (s == 0) begin
            v = longint'(p);
            e.lat = 2;
        end else if (s < -32) begin
            v = 0;
            e.lat = 2;
        end else if (s < 0) begin
            v = (longint'(p) >> (-s)) + ((longint'(p) >> (-s - 1)) & 64'd1);
            e.lat = -s + 2;
        end else begin
            v = longint'(p) << s;
            e.lat = s + 2;
            // Overflow is seen once the MSB reaches bit 31, in shift cycle 32-msb.
            if (v > 64'hFFFF_FFFF) e.lat = 33 - msb;
        end
        if (v > 64'hFFFF_FFFF) begin
            e.y   = 32'hFFFF_FFFF;
            e.sat = 1'b1;
        end else begin
            e.y = v[31:0];
        end
        e.uflow = (p != 0) && (e.y == 0);
        return e;
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge CLK);
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard push on accept, then monitor compare just after the edge.
    initial begin
        bit          in_hold;
        logic [31:0] held_y;
        exp_t        e;
        in_hold = 1'b0;
        held_y  = '0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (rst_n && in_valid && in_ready) begin
                e = model(p_in, k_in);
                e.acc = cyc;
                exp_q.push_back(e);
                acc_cnt++;
            end
            #1;
            if (!rst_n) begin
                in_hold = 1'b0;
            end else if (out_valid && !in_hold) begin
                in_hold = 1'b1;
                held_y  = y_out;
                if (exp_q.size() == 0) begin
                    timeout("unexpected_out_valid");
                end else begin
                    e = exp_q.pop_front();
                    chk("y_out", {32'd0, y_out}, {32'd0, e.y});
                    chk("sat", {63'd0, sat}, {63'd0, e.sat});
                    chk("uflow", {63'd0, uflow}, {63'd0, e.uflow});
                    chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                end
                chk("in_ready_in_hold", {63'd0, in_ready}, 64'd0);
            end else if (out_valid) begin
                chk("y_out_stable", {32'd0, y_out}, {32'd0, held_y});
                chk("in_ready_in_hold", {63'd0, in_ready}, 64'd0);
            end else begin
                in_hold = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] p, input logic [5:0] k);
        int  n0;
        bit  ok;
        @(negedge CLK);
        p_in     = p;
        k_in     = k;
        in_valid = 1'b1;
        n0       = acc_cnt;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (acc_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) timeout("accept");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !out_valid && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("drain");
    endtask

    initial begin
        bit ok;
        logic [31:0] p;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        p_in     = '0;
        k_in     = '0;
        repeat (3) @(negedge CLK);
        chk("rst_y_out", {32'd0, y_out}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sat", {63'd0, sat}, 64'd0);
        chk("rst_uflow", {63'd0, uflow}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;

        // 1.0 * 2^0
        issue(32'h4000_0000, 6'd0);
        wait_idle();

        // 1.5 * 2^3 held for 5 cycles while in_valid pulses must be ignored
        ready_mode = 0;
        issue(32'h6000_0000, 6'd3);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("hold_out_valid");
        for (int i = 0; i < 5; i++) begin
            p_in     = $urandom;
            k_in     = 6'($urandom);
            in_valid = (i % 2 == 0);
            @(negedge CLK);
        end
        in_valid   = 1'b0;
        ready_mode = 1;
        wait_idle();

        // Rounding, saturation, underflow shortcut
        issue(32'h0000_2000, 6'd0);
        issue(32'h0000_1FFF, 6'd0);
        issue(32'h4000_0000, 6'd31);
        issue(32'h4000_0000, 6'h20);
        issue(32'h0000_0000, 6'd5);
        issue(32'hFFFF_FFFF, 6'd14);
        issue(32'h8000_0000, 6'h2E);
        wait_idle();

        // Reset in the middle of a shift sequence
        issue(32'h4000_0000, 6'd0);
        repeat (5) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        @(negedge CLK);
        rst_n = 1'b1;
        issue(32'h4000_0000, 6'd1);
        wait_idle();

        // Random jobs with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            p = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) p = 32'd0;
            issue(p, 6'($urandom));
        end
        ready_mode = 1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/taylor_exp_reconstruct.md
Name: taylor_exp_reconstruct

Overview:
- Downstream neighbour of the Taylor stage-3 datapath in the exponential unit.
- Consumes the polynomial result p ≈ e^r in Q2.30 and the range-reduction exponent k, then produces y = p·2^k in Q16.16.
- Scaling uses an iterative one-bit-per-cycle shifter, followed by round-half-up, saturation and underflow flags.
- Holds the result on a valid/ready output handshake until the consumer takes it.

Parameters:
- DW, 32, width of p_in, internal shift register and y_out.
- FRAC_IN, 30, fractional bits of p_in.
- FRAC_OUT, 16, fractional bits of y_out.
- KW, 6, width of signed k_in (two's complement).

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  stage-3 result strobe (driven from stage-3 output_ready).
- in_ready  out  1  high only in IDLE.
- p_in  in  DW  polynomial result, unsigned Q2.30.
- k_in  in  KW  signed exponent.
- y_out  out  DW  unsigned Q16.16 result, stable while out_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- sat  out  1  result saturated to all ones; valid with out_valid.
- uflow  out  1  p_in nonzero but y_out is 0; valid with out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: already decided — one clock, asynchronous active-low reset (rst_n).
  - Reset forces state IDLE, y_out=0, out_valid=0, sat=0, uflow=0, busy=0, in_ready=1.
  - Reset mid-operation discards the job; no output is produced.
- Shift amount: s = k_in − (FRAC_IN − FRAC_OUT) = k_in − 14.
  - Computed signed, KW+2 bits wide.
  - Default range is −46..17.
- States:
  - IDLE
  - SHIFT
  - ROUND
  - HOLD
- IDLE:
  - On in_valid: load reg=p_in, guard=0, cnt=|s|, dir=sign(s).
  - If s==0, go to ROUND.
  - If s < −DW, force reg=0 and guard=0, set uflow=(p_in!=0), go to ROUND.
  - Otherwise go to SHIFT.
  - in_valid in any other state is ignored (no queuing).
- SHIFT, right (s<0):
  - guard ← reg[0], reg ← reg>>1, cnt−1.
  - When cnt reaches 1 this cycle, go to ROUND.
  - Bits below the guard bit are discarded (no sticky bit).
- SHIFT, left (s>0):
  - If reg[DW−1]==1 before the shift: y_out=all ones, sat=1, go directly to HOLD.
  - Otherwise reg ← reg<<1 and cnt−1; go to ROUND at the last shift.
- ROUND:
  - y_out ← reg + guard.
  - If reg is all ones and guard=1: y_out=all ones, sat=1.
  - uflow is set if p_in!=0 and the final y_out==0.
  - Go to HOLD.
- HOLD:
  - out_valid=1; y_out, sat and uflow are frozen.
  - On out_ready: go to IDLE the next cycle, out_valid falls, in_ready rises.
  - A new job cannot be accepted in the same cycle as the handshake.
- sat and uflow clear when a new job is accepted.
- Latency, counted as cycles from the accept edge to out_valid high:
  - |s|+2 in the normal case.
  - 2 when s==0 or the result is forced to zero.
  - j+1 when saturation is detected in SHIFT cycle j.
- Throughput: one job per latency+1 cycles minimum.

Test Plan:
- p_in=0x4000_0000 (1.0), k_in=0 → s=−14; out_valid after 16 cycles; y_out=0x0001_0000, sat=0, uflow=0.
- p_in=0x6000_0000 (1.5), k_in=3 → y_out=0x000C_0000 after 13 cycles; hold out_ready=0 for 5 cycles and confirm y_out is stable and in_valid pulses are ignored.
- Rounding: p_in=0x0000_2000, k_in=0 → y_out=0x0000_0001, uflow=0; p_in=0x0000_1FFF, k_in=0 → y_out=0, uflow=1.
- Saturation: p_in=0x4000_0000, k_in=31 → detected at SHIFT cycle 2; out_valid at cycle 3, y_out=0xFFFF_FFFF, sat=1.
- Underflow shortcut: p_in=0x4000_0000, k_in=−32 → s=−46; out_valid after 2 cycles, y_out=0, uflow=1.
- Reset mid-SHIFT: assert rst_n=0 during a k_in=0 job → out_valid=0, busy=0, in_ready=1 immediately; after release, a new p_in=0x4000_0000, k_in=1 job yields 0x0002_0000.
